// File: rtl/gpr_read_mux_bank.sv
// gpr_read_mux_bank: register bank with one write port and two registered
// read ports (A and B). It has write-to-read bypass, a synchronous clear and
// an out-of-range select flag. Reads complete one cycle after rd_req.
//
// Read handshake: rd_req has no ready partner and is always accepted. Each
// clk edge that sees rd_req=1 produces exactly one result. On the following
// cycle out_valid is high for one cycle, and out_a/out_b/sel_err hold that
// result. Back-to-back requests keep out_valid high continuously. out_a and
// out_b keep their last value while no request is made. An asynchronous
// reset discards any request in flight.
module gpr_read_mux_bank #(
   parameter int               WIDTH   = 8,
   parameter int               NREG    = 4,
   parameter int               SELW    = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [SELW-1:0]  waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             clr,
   input  logic             rd_req,
   input  logic [SELW-1:0]  sel_a,
   input  logic [SELW-1:0]  sel_b,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_valid,
   output logic             sel_err
);

   logic [WIDTH-1:0] regs [NREG];
   logic             waddr_ok;
   logic             write_hit;
   logic [SELW-1:0]  sel     [2];
   logic [WIDTH-1:0] val     [2];
   logic             sel_bad [2];

   assign sel[0] = sel_a;
   assign sel[1] = sel_b;

   // A write is only meaningful when it targets an existing register.
   always_comb begin
      waddr_ok  = (32'(waddr) < NREG);
      write_hit = we && waddr_ok && !clr;
   end

   // Per-port value selection, in priority order: clear, bypass, stored value, zero.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         val[p]     = '0;
         sel_bad[p] = (32'(sel[p]) >= NREG);
         if (clr)
            val[p] = RST_VAL;
         else if (we && waddr_ok && (waddr == sel[p]))
            val[p] = wdata;
         else if (!sel_bad[p])
            val[p] = regs[sel[p]];
      end
   end

   // Storage: clear beats write; out-of-range writes are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= RST_VAL;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (clr)
               regs[i] <= RST_VAL;
            else if (write_hit && (32'(waddr) == i))
               regs[i] <= wdata;
         end
      end
   end

   // Registered read results; data holds between requests, valid/err pulse per request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_a     <= '0;
         out_b     <= '0;
         out_valid <= 1'b0;
         sel_err   <= 1'b0;
      end else if (rd_req) begin
         out_a     <= val[0];
         out_b     <= val[1];
         out_valid <= 1'b1;
         sel_err   <= sel_bad[0] | sel_bad[1];
      end else begin
         out_valid <= 1'b0;
         sel_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gpr_read_mux_bank.sv
// Directed bench for gpr_read_mux_bank. It uses a default 4x8 instance and a
// non-power-of-two 5-register instance with SELW=3.
module tb_gpr_read_mux_bank;

   logic       clk = 1'b0;
   logic       rst;

   // default instance (NREG=4, SELW=2)
   logic       we, clr, rd_req;
   logic [1:0] waddr, sel_a, sel_b;
   logic [7:0] wdata, out_a, out_b;
   logic       out_valid, sel_err;

   // five-register instance (NREG=5, SELW=3)
   logic       we5, clr5, rd_req5;
   logic [2:0] waddr5, sel_a5, sel_b5;
   logic [7:0] wdata5, out_a5, out_b5;
   logic       out_valid5, sel_err5;

   int         n_checks = 0;
   int         n_fail   = 0;

   logic [7:0] vals [4];

   gpr_read_mux_bank dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
      .rd_req(rd_req), .sel_a(sel_a), .sel_b(sel_b), .out_a(out_a), .out_b(out_b),
      .out_valid(out_valid), .sel_err(sel_err)
   );

   gpr_read_mux_bank #(.WIDTH(8), .NREG(5), .SELW(3)) dut5 (
      .clk(clk), .rst(rst), .we(we5), .waddr(waddr5), .wdata(wdata5), .clr(clr5),
      .rd_req(rd_req5), .sel_a(sel_a5), .sel_b(sel_b5), .out_a(out_a5), .out_b(out_b5),
      .out_valid(out_valid5), .sel_err(sel_err5)
   );

   // clock
   always #5 clk = ~clk;

   // Single checking task; every comparison goes through here.
   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance past the next rising edge; outputs are then stable for sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 0; clr = 0; rd_req = 0; waddr = 0; wdata = 0; sel_a = 0; sel_b = 0;
      we5 = 0; clr5 = 0; rd_req5 = 0; waddr5 = 0; wdata5 = 0; sel_a5 = 0; sel_b5 = 0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      we = 1; waddr = a; wdata = d;
      tick();
      we = 0;
   endtask

   task automatic wr5(input logic [2:0] a, input logic [7:0] d);
      we5 = 1; waddr5 = a; wdata5 = d;
      tick();
      we5 = 0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [1:0] b);
      rd_req = 1; sel_a = a; sel_b = b;
      tick();
      rd_req = 0;
   endtask

   task automatic rd5(input logic [2:0] a, input logic [2:0] b);
      rd_req5 = 1; sel_a5 = a; sel_b5 = b;
      tick();
      rd_req5 = 0;
   endtask

   initial begin
      idle();
      vals[0] = 8'h10; vals[1] = 8'h21; vals[2] = 8'h32; vals[3] = 8'h43;

      // reset
      rst = 1;
      repeat (3) tick();
      check("rst_out_a", out_a, 0);
      check("rst_out_b", out_b, 0);
      check("rst_valid", out_valid, 0);
      check("rst_err", sel_err, 0);
      rst = 0;
      tick();

      // 1: read after reset
      rd(2'd0, 2'd3);
      check("t1_a", out_a, 8'h00);
      check("t1_b", out_b, 8'h00);
      check("t1_valid", out_valid, 1);
      check("t1_err", sel_err, 0);
      tick();
      check("t1_valid_drop", out_valid, 0);

      // 2: write then read ordering, hold after rd_req drops
      wr(2'd1, 8'h5A);
      tick();
      wr(2'd2, 8'hC3);
      rd(2'd1, 2'd2);
      check("t2_a", out_a, 8'h5A);
      check("t2_b", out_b, 8'hC3);
      check("t2_valid", out_valid, 1);
      tick();
      tick();
      check("t2_hold_a", out_a, 8'h5A);
      check("t2_hold_b", out_b, 8'hC3);
      check("t2_hold_valid", out_valid, 0);

      // 3: bypass
      wr(2'd3, 8'h11);
      we = 1; waddr = 2'd3; wdata = 8'h99;
      rd(2'd3, 2'd3);
      we = 0;
      check("t3_byp_a", out_a, 8'h99);
      check("t3_byp_b", out_b, 8'h99);
      rd(2'd3, 2'd1);
      check("t3_after_a", out_a, 8'h99);
      check("t3_after_b", out_b, 8'h5A);

      // 4: clear beats same-cycle write and bypass
      wr(2'd0, 8'h7F);
      clr = 1; we = 1; waddr = 2'd0; wdata = 8'h22;
      rd(2'd0, 2'd1);
      clr = 0; we = 0;
      check("t4_clr_a", out_a, 8'h00);
      check("t4_clr_b", out_b, 8'h00);
      rd(2'd0, 2'd3);
      check("t4_after_a", out_a, 8'h00);
      check("t4_after_b", out_b, 8'h00);

      // 5: five-register instance, out-of-range selects and writes
      wr5(3'd4, 8'hA4);
      wr5(3'd0, 8'h01);
      wr5(3'd7, 8'hFF);
      rd5(3'd6, 3'd4);
      check("t5_oor_a", out_a5, 8'h00);
      check("t5_oor_b", out_b5, 8'hA4);
      check("t5_oor_err", sel_err5, 1);
      check("t5_oor_valid", out_valid5, 1);
      rd5(3'd0, 3'd4);
      check("t5_r0", out_a5, 8'h01);
      check("t5_r4", out_b5, 8'hA4);
      check("t5_inrange_err", sel_err5, 0);
      rd5(3'd1, 3'd3);
      check("t5_r1", out_a5, 8'h00);
      check("t5_r3", out_b5, 8'h00);
      rd5(3'd2, 3'd2);
      check("t5_r2", out_a5, 8'h00);
      tick();
      check("t5_err_drop", sel_err5, 0);

      // 6: streaming reads
      for (int i = 0; i < 4; i++) wr(2'(i), vals[i]);
      rd_req = 1;
      for (int i = 0; i < 4; i++) begin
         sel_a = 2'(i); sel_b = 2'(3 - i);
         tick();
         check($sformatf("t6_stream_valid%0d", i), out_valid, 1);
         check($sformatf("t6_stream_a%0d", i), out_a, vals[i]);
         check($sformatf("t6_stream_b%0d", i), out_b, vals[3 - i]);
      end
      rd_req = 0;
      tick();
      check("t6_stream_end", out_valid, 0);

      // 6b: streaming with reset pulsed during the third cycle
      rd_req = 1;
      for (int i = 0; i < 2; i++) begin
         sel_a = 2'(i); sel_b = 2'(3 - i);
         tick();
         check($sformatf("t6r_valid%0d", i), out_valid, 1);
         check($sformatf("t6r_a%0d", i), out_a, vals[i]);
      end
      sel_a = 2'd2; sel_b = 2'd1;
      #2 rst = 1;
      #1;
      check("t6r_async_a", out_a, 0);
      check("t6r_async_b", out_b, 0);
      check("t6r_async_valid", out_valid, 0);
      tick();
      check("t6r_inrst_valid", out_valid, 0);
      rd_req = 0;
      rst = 0;
      tick();
      check("t6r_post_valid", out_valid, 0);
      check("t6r_post_a", out_a, 0);
      tick();
      check("t6r_post_valid2", out_valid, 0);
      rd(2'd1, 2'd3);
      check("t6r_fresh_valid", out_valid, 1);
      check("t6r_fresh_a", out_a, 8'h00);
      check("t6r_fresh_b", out_b, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
